// File: rtl/mem_decoder_seq.sv
// Registered, handshaked memory decoder: maps MIPS virtual addresses onto the
// RAM/VGA/I/O banks, inserts per-bank wait states and captures the first fault.
module mem_decoder_seq #(
    parameter int unsigned        PADDR_W     = 13,
    parameter logic [31:0]        DATA_BASE   = 32'h10010000,
    parameter logic [31:0]        DATA_LAST   = 32'h10010FFF,
    parameter logic [31:0]        STACK_BASE  = 32'h7FFFEFFC,
    parameter logic [31:0]        STACK_LAST  = 32'h7FFFFFFB,
    parameter logic [PADDR_W-1:0] STACK_PBASE = 'h1000,
    parameter logic [31:0]        VGA_BASE    = 32'h0000B800,
    parameter logic [31:0]        VGA_LAST    = 32'h0000CABF,
    parameter logic [31:0]        IO_BASE     = 32'hFFFF0000,
    parameter logic [31:0]        IO_LAST     = 32'hFFFF000F,
    parameter int unsigned        WAIT_RAM    = 0,
    parameter int unsigned        WAIT_VGA    = 1,
    parameter int unsigned        WAIT_IO     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        vAddr,
    input  logic               mWrite,
    input  logic               mRead,
    output logic [PADDR_W-1:0] pAddr,
    output logic [2:0]         mEnab,
    output logic [1:0]         mBank,
    output logic               mWe,
    output logic               resp_valid,
    output logic               iAddr,
    output logic               fault_valid,
    output logic [31:0]        fault_vaddr,
    output logic               fault_write,
    output logic               fault_ovf,
    input  logic               fault_clr
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FAULT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PADDR_W-1:0]  paddr_q, paddr_d;
    logic [2:0]          enab_q, enab_d;
    logic [1:0]          bank_q, bank_d;
    logic                we_q, we_d;

    logic                fv_q, fv_d;
    logic [31:0]         fa_q, fa_d;
    logic                fw_q, fw_d;
    logic                fo_q, fo_d;

    logic                accept;
    logic                dec_ok;
    logic [PADDR_W-1:0]  dec_paddr;
    logic [1:0]          dec_bank;
    logic [2:0]          dec_enab;
    logic [3:0]          dec_wait;
    logic [31:0]         dec_off;

    // Handshake: only IDLE accepts, and never while reset is held.
    always_comb begin
        req_ready = (state_q == IDLE) && !rst;
        accept    = req_valid && req_ready;
    end

    // Region decode; regions do not overlap so the priority order is irrelevant.
    always_comb begin
        dec_ok   = 1'b1;
        dec_bank = 2'd0;
        dec_wait = 4'(WAIT_RAM);
        dec_off  = 32'd0;
        if ((vAddr >= DATA_BASE) && (vAddr <= DATA_LAST)) begin
            dec_off = vAddr - DATA_BASE;
        end else if ((vAddr >= STACK_BASE) && (vAddr <= STACK_LAST)) begin
            dec_off = vAddr - STACK_BASE + 32'(STACK_PBASE);
        end else if ((vAddr >= VGA_BASE) && (vAddr <= VGA_LAST)) begin
            dec_off  = vAddr - VGA_BASE;
            dec_bank = 2'd1;
            dec_wait = 4'(WAIT_VGA);
        end else if ((vAddr >= IO_BASE) && (vAddr <= IO_LAST)) begin
            dec_off  = vAddr - IO_BASE;
            dec_bank = 2'd2;
            dec_wait = 4'(WAIT_IO);
        end else begin
            dec_ok = 1'b0;
        end
        // Exactly one of read/write makes a legal request.
        if (mRead == mWrite) begin
            dec_ok = 1'b0;
        end
        dec_paddr = dec_off[PADDR_W-1:0];
        unique case (dec_bank)
            2'd1:    dec_enab = 3'b010;
            2'd2:    dec_enab = 3'b100;
            default: dec_enab = 3'b001;
        endcase
    end

    // Next-state and next-output logic for the access FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        paddr_d = paddr_q;
        enab_d  = enab_q;
        bank_d  = bank_q;
        we_d    = we_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dec_ok) begin
                        state_d = ACCESS;
                        cnt_d   = dec_wait;
                        paddr_d = dec_paddr;
                        enab_d  = dec_enab;
                        bank_d  = dec_bank;
                        we_d    = mWrite;
                    end else begin
                        state_d = FAULT;
                        cnt_d   = 4'd0;
                        paddr_d = '0;
                        enab_d  = 3'b000;
                        bank_d  = 2'd0;
                        we_d    = 1'b0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    paddr_d = '0;
                    enab_d  = 3'b000;
                    bank_d  = 2'd0;
                    we_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            FAULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                paddr_d = '0;
                enab_d  = 3'b000;
                bank_d  = 2'd0;
                we_d    = 1'b0;
            end
        endcase
    end

    // State and registered bank-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            paddr_q <= '0;
            enab_q  <= 3'b000;
            bank_q  <= 2'd0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            paddr_q <= paddr_d;
            enab_q  <= enab_d;
            bank_q  <= bank_d;
            we_q    <= we_d;
        end
    end

    // Fault capture: first fault wins; a clear coincident with a new fault
    // starts a fresh capture with the overflow flag cleared.
    always_comb begin
        fv_d = fv_q;
        fa_d = fa_q;
        fw_d = fw_q;
        fo_d = fo_q;
        if (accept && !dec_ok) begin
            if (!fv_q || fault_clr) begin
                fv_d = 1'b1;
                fa_d = vAddr;
                fw_d = mWrite;
                fo_d = 1'b0;
            end else begin
                fo_d = 1'b1;
            end
        end else if (fault_clr) begin
            fv_d = 1'b0;
            fa_d = 32'd0;
            fw_d = 1'b0;
            fo_d = 1'b0;
        end
    end

    // Fault capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fv_q <= 1'b0;
            fa_q <= 32'd0;
            fw_q <= 1'b0;
            fo_q <= 1'b0;
        end else begin
            fv_q <= fv_d;
            fa_q <= fa_d;
            fw_q <= fw_d;
            fo_q <= fo_d;
        end
    end

    // Completion pulse is decoded from the state so it never lags the access.
    always_comb begin
        resp_valid  = ((state_q == ACCESS) && (cnt_q == 4'd0)) || (state_q == FAULT);
        iAddr       = (state_q == FAULT);
        pAddr       = paddr_q;
        mEnab       = enab_q;
        mBank       = bank_q;
        mWe         = we_q;
        fault_valid = fv_q;
        fault_vaddr = fa_q;
        fault_write = fw_q;
        fault_ovf   = fo_q;
    end

endmodule

// File: tb/tb_mem_decoder_seq.sv
// Self-checking bench for mem_decoder_seq: directed cases then random requests
// checked against a region-table reference model.
module tb_mem_decoder_seq;

    localparam int unsigned PW         = 13;
    localparam logic [31:0] DATA_BASE  = 32'h10010000;
    localparam logic [31:0] DATA_LAST  = 32'h10010FFF;
    localparam logic [31:0] STACK_BASE = 32'h7FFFEFFC;
    localparam logic [31:0] STACK_LAST = 32'h7FFFFFFB;
    localparam logic [31:0] STACK_PB   = 32'h00001000;
    localparam logic [31:0] VGA_BASE   = 32'h0000B800;
    localparam logic [31:0] VGA_LAST   = 32'h0000CABF;
    localparam logic [31:0] IO_BASE    = 32'hFFFF0000;
    localparam logic [31:0] IO_LAST    = 32'hFFFF000F;
    localparam int          W_RAM      = 0;
    localparam int          W_VGA      = 1;
    localparam int          W_IO       = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   vAddr;
    logic          mWrite;
    logic          mRead;
    logic [PW-1:0] pAddr;
    logic [2:0]    mEnab;
    logic [1:0]    mBank;
    logic          mWe;
    logic          resp_valid;
    logic          iAddr;
    logic          fault_valid;
    logic [31:0]   fault_vaddr;
    logic          fault_write;
    logic          fault_ovf;
    logic          fault_clr;

    int checks   = 0;
    int failures = 0;

    // Reference fault capture state.
    logic        m_fv = 1'b0;
    logic [31:0] m_fa = 32'd0;
    logic        m_fw = 1'b0;
    logic        m_fo = 1'b0;

    always #5 clk = ~clk;

    mem_decoder_seq dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .vAddr       (vAddr),
        .mWrite      (mWrite),
        .mRead       (mRead),
        .pAddr       (pAddr),
        .mEnab       (mEnab),
        .mBank       (mBank),
        .mWe         (mWe),
        .resp_valid  (resp_valid),
        .iAddr       (iAddr),
        .fault_valid (fault_valid),
        .fault_vaddr (fault_vaddr),
        .fault_write (fault_write),
        .fault_ovf   (fault_ovf),
        .fault_clr   (fault_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Region table lookup straight from the address map.
    task automatic ref_decode(input logic [31:0] v, input logic rd, input logic wr,
                              output logic ok, output logic [31:0] pa,
                              output logic [31:0] bank, output int w);
        logic [31:0] t;
        ok = 1'b1; t = 32'd0; bank = 0; w = W_RAM;
        if (v >= DATA_BASE && v <= DATA_LAST) t = v - DATA_BASE;
        else if (v >= STACK_BASE && v <= STACK_LAST) t = v - STACK_BASE + STACK_PB;
        else if (v >= VGA_BASE && v <= VGA_LAST) begin t = v - VGA_BASE; bank = 1; w = W_VGA; end
        else if (v >= IO_BASE && v <= IO_LAST) begin t = v - IO_BASE; bank = 2; w = W_IO; end
        else ok = 1'b0;
        if (rd == wr) ok = 1'b0;
        pa = t % 32'h2000;
    endtask

    task automatic chk_fault_regs(input string tag);
        chk({tag, "_fv"}, 32'(fault_valid), 32'(m_fv));
        chk({tag, "_fa"}, fault_vaddr, m_fa);
        chk({tag, "_fw"}, 32'(fault_write), 32'(m_fw));
        chk({tag, "_fo"}, 32'(fault_ovf), 32'(m_fo));
    endtask

    // Issue one request from IDLE and check every cycle until back in IDLE.
    task automatic do_req(input logic [31:0] v, input logic rd, input logic wr,
                          input logic clr);
        logic        ok;
        logic [31:0] pa;
        logic [31:0] bank;
        int          w;
        int          budget;
        ref_decode(v, rd, wr, ok, pa, bank, w);
        budget = 0;
        while (!req_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("ready_idle", 32'(req_ready), 32'd1);
        vAddr = v; mRead = rd; mWrite = wr; req_valid = 1'b1; fault_clr = clr;
        @(posedge clk);
        if (!ok) begin
            if (!m_fv || clr) begin
                m_fv = 1'b1; m_fa = v; m_fw = wr; m_fo = 1'b0;
            end else begin
                m_fo = 1'b1;
            end
        end else if (clr) begin
            m_fv = 1'b0; m_fa = 32'd0; m_fw = 1'b0; m_fo = 1'b0;
        end
        @(negedge clk);
        // Scrambled inputs outside IDLE must be ignored.
        req_valid = 1'b1; fault_clr = 1'b0; vAddr = $urandom;
        mRead = 1'($urandom); mWrite = 1'($urandom);
        if (ok) begin
            for (int k = 0; k <= w; k++) begin
                req_valid = (k == w) ? 1'b0 : 1'b1;
                chk("acc_paddr", 32'(pAddr), pa);
                chk("acc_enab", 32'(mEnab), 32'd1 << bank);
                chk("acc_bank", 32'(mBank), bank);
                chk("acc_we", 32'(mWe), 32'(wr));
                chk("acc_resp", 32'(resp_valid), (k == w) ? 32'd1 : 32'd0);
                chk("acc_iaddr", 32'(iAddr), 32'd0);
                chk("acc_ready", 32'(req_ready), 32'd0);
                if (k < w) @(negedge clk);
            end
        end else begin
            req_valid = 1'b0;
            chk("flt_resp", 32'(resp_valid), 32'd1);
            chk("flt_iaddr", 32'(iAddr), 32'd1);
            chk("flt_enab", 32'(mEnab), 32'd0);
            chk("flt_paddr", 32'(pAddr), 32'd0);
            chk("flt_bank", 32'(mBank), 32'd0);
            chk("flt_we", 32'(mWe), 32'd0);
            chk("flt_ready", 32'(req_ready), 32'd0);
        end
        chk_fault_regs("req");
        req_valid = 1'b0; mRead = 1'b0; mWrite = 1'b0;
        @(negedge clk);
        chk("post_ready", 32'(req_ready), 32'd1);
        chk("post_resp", 32'(resp_valid), 32'd0);
        chk("post_enab", 32'(mEnab), 32'd0);
        chk("post_we", 32'(mWe), 32'd0);
        chk("post_paddr", 32'(pAddr), 32'd0);
    endtask

    logic [31:0] misses [8];

    initial begin
        rst = 1'b1; req_valid = 1'b0; vAddr = 32'd0; mWrite = 1'b0; mRead = 1'b0;
        fault_clr = 1'b0;
        misses[0] = DATA_BASE - 1;  misses[1] = DATA_LAST + 1;
        misses[2] = STACK_BASE - 1; misses[3] = STACK_LAST + 1;
        misses[4] = VGA_BASE - 1;   misses[5] = VGA_LAST + 1;
        misses[6] = IO_BASE - 1;    misses[7] = IO_LAST + 1;

        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_enab", 32'(mEnab), 32'd0);
        chk("rst_paddr", 32'(pAddr), 32'd0);
        chk("rst_resp", 32'(resp_valid), 32'd0);
        chk_fault_regs("rst");
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the address map boundaries.
        do_req(32'h10010003, 1'b1, 1'b0, 1'b0);
        do_req(32'h7FFFEFFC, 1'b0, 1'b1, 1'b0);
        do_req(32'h7FFFFFFB, 1'b1, 1'b0, 1'b0);
        do_req(32'h7FFFEFFB, 1'b1, 1'b0, 1'b0);
        do_req(32'h7FFFFFFC, 1'b1, 1'b0, 1'b0);
        do_req(32'h0000CABF, 1'b1, 1'b0, 1'b0);
        do_req(32'hFFFF000F, 1'b0, 1'b1, 1'b0);
        do_req(32'hFFFF0010, 1'b1, 1'b0, 1'b0);

        // Standalone clear, then first-fault capture and overflow.
        fault_clr = 1'b1;
        @(posedge clk);
        m_fv = 1'b0; m_fa = 32'd0; m_fw = 1'b0; m_fo = 1'b0;
        @(negedge clk);
        fault_clr = 1'b0;
        chk_fault_regs("clr0");
        do_req(32'h10011000, 1'b1, 1'b0, 1'b0);
        do_req(32'h0000B7FF, 1'b0, 1'b1, 1'b0);
        fault_clr = 1'b1;
        @(posedge clk);
        m_fv = 1'b0; m_fa = 32'd0; m_fw = 1'b0; m_fo = 1'b0;
        @(negedge clk);
        fault_clr = 1'b0;
        chk_fault_regs("clr1");
        do_req(32'h10010000, 1'b1, 1'b1, 1'b0);
        do_req(32'h10010000, 1'b0, 1'b0, 1'b0);
        do_req(32'h00000000, 1'b1, 1'b0, 1'b1);

        // Reset during the second cycle of an I/O access.
        vAddr = 32'hFFFF0004; mWrite = 1'b1; mRead = 1'b0; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; mWrite = 1'b0;
        chk("mid_enab1", 32'(mEnab), 32'd4);
        @(negedge clk);
        chk("mid_resp2", 32'(resp_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        m_fv = 1'b0; m_fa = 32'd0; m_fw = 1'b0; m_fo = 1'b0;
        @(negedge clk);
        chk("mid_enab", 32'(mEnab), 32'd0);
        chk("mid_paddr", 32'(pAddr), 32'd0);
        chk("mid_bank", 32'(mBank), 32'd0);
        chk("mid_we", 32'(mWe), 32'd0);
        chk("mid_resp", 32'(resp_valid), 32'd0);
        chk("mid_iaddr", 32'(iAddr), 32'd0);
        chk_fault_regs("mid");
        rst = 1'b0;
        @(negedge clk);
        chk("mid_ready", 32'(req_ready), 32'd1);
        chk("mid_resp_after", 32'(resp_valid), 32'd0);

        // Random requests: in-region, boundary misses and arbitrary addresses.
        for (int i = 0; i < 150; i++) begin
            logic [31:0] v;
            logic        rd, wr;
            int          sel, rw;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: v = DATA_BASE + $urandom_range(0, 32'hFFF);
                1: v = STACK_BASE + $urandom_range(0, 32'hFFF);
                2: v = VGA_BASE + $urandom_range(0, 32'h12BF);
                3: v = IO_BASE + $urandom_range(0, 15);
                4: v = misses[$urandom_range(0, 7)];
                default: v = $urandom;
            endcase
            rw = int'($urandom_range(0, 7));
            if (rw == 0) begin rd = 1'b1; wr = 1'b1; end
            else if (rw == 1) begin rd = 1'b0; wr = 1'b0; end
            else begin rd = 1'($urandom); wr = ~rd; end
            do_req(v, rd, wr, ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
